// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package mcycle_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mcycle_state_e;

  localparam logic       MCYCLE_MUL   = 1'b0;
  localparam logic       MCYCLE_DIV   = 1'b1;
  localparam logic [1:0] ALU_CTRL_ADD = 2'b00;
  localparam logic [1:0] ALU_CTRL_SUB = 2'b01;
  localparam int         FLAG_C_IDX   = 1;
  localparam int         ITER_COUNT   = 32;

  localparam int               CNT_W    = $clog2(ITER_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

endpackage

// File: rtl/mcycle_negate.sv
// Two's-complement conditional negate; driving en_i with the MSB gives abs().
module mcycle_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         en_i,
  output logic [W-1:0] out_o
);

  logic [W-1:0] one_s;

  assign one_s = {{(W-1){1'b0}}, 1'b1};

  // Negate when enabled, otherwise pass through.
  always_comb begin
    if (en_i) begin
      out_o = ~in_i + one_s;
    end else begin
      out_o = in_i;
    end
  end

endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle multiply/divide sequencer time-sharing an external 32-bit ALU.
// Signed operation and the FIX state exist only when MCYCLE_SIGNED_EN is defined.
module mcycle_seq
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             DivZero,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALU_SrcA,
  output logic [WIDTH-1:0] ALU_SrcB,
  output logic [1:0]       ALU_Control,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic [3:0]       ALU_Flags
);

  mcycle_state_e    state_q;
  logic             op_q;
  logic [CNT_W-1:0] cnt_q;
  // hi holds the product high word / remainder, lo the multiplier / dividend-quotient
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opb_q;

  logic [WIDTH-1:0] rem_sh_s;
  logic [WIDTH-1:0] acc_hi_d;
  logic [WIDTH-1:0] acc_lo_d;
  logic             alu_c_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             need_fix_s;
  logic             unused_flags_s;

  assign unused_flags_s = ^{ALU_Flags[3:2], ALU_Flags[0]};
  assign alu_c_s        = ALU_Flags[FLAG_C_IDX];
  assign rem_sh_s       = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};

`ifdef MCYCLE_SIGNED_EN
  logic               signed_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               sgn_a_s;
  logic               sgn_b_s;
  logic [2*WIDTH-1:0] prod_neg_s;
  logic [WIDTH-1:0]   quo_neg_s;
  logic [WIDTH-1:0]   rem_neg_s;

  assign sgn_a_s    = signed_q & acc_lo_q[WIDTH-1];
  assign sgn_b_s    = signed_q & opb_q[WIDTH-1];
  assign need_fix_s = neg_lo_q | neg_hi_q;

  mcycle_negate #(.W(WIDTH)) u_abs_a (.in_i(acc_lo_q), .en_i(sgn_a_s), .out_o(mag_a_s));
  mcycle_negate #(.W(WIDTH)) u_abs_b (.in_i(opb_q),    .en_i(sgn_b_s), .out_o(mag_b_s));
  mcycle_negate #(.W(2*WIDTH)) u_neg_prod (
    .in_i ({acc_hi_q, acc_lo_q}),
    .en_i (neg_lo_q),
    .out_o(prod_neg_s)
  );
  mcycle_negate #(.W(WIDTH)) u_neg_quo (.in_i(acc_lo_q), .en_i(neg_lo_q), .out_o(quo_neg_s));
  mcycle_negate #(.W(WIDTH)) u_neg_rem (.in_i(acc_hi_q), .en_i(neg_hi_q), .out_o(rem_neg_s));
`else
  logic unused_signed_s;

  assign unused_signed_s = Signed;
  assign mag_a_s         = acc_lo_q;
  assign mag_b_s         = opb_q;
  assign need_fix_s      = 1'b0;
`endif

  // ALU operand steering and one shift-add / restoring-division step.
  always_comb begin
    ALU_SrcA    = '0;
    ALU_SrcB    = '0;
    ALU_Control = ALU_CTRL_ADD;
    if (state_q == ITER) begin
      ALU_SrcB = opb_q;
      if (op_q == MCYCLE_MUL) begin
        ALU_SrcA    = acc_hi_q;
        ALU_Control = ALU_CTRL_ADD;
      end else begin
        ALU_SrcA    = rem_sh_s;
        ALU_Control = ALU_CTRL_SUB;
      end
    end else begin
      ALU_SrcA = '0;
    end

    if (op_q == MCYCLE_MUL) begin
      if (acc_lo_q[0]) begin
        acc_hi_d = {alu_c_s, ALU_Result[WIDTH-1:1]};
        acc_lo_d = {ALU_Result[0], acc_lo_q[WIDTH-1:1]};
      end else begin
        acc_hi_d = {1'b0, acc_hi_q[WIDTH-1:1]};
        acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
      end
    end else begin
      if (alu_c_s) begin
        acc_hi_d = ALU_Result;
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_d = rem_sh_s;
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      op_q     <= MCYCLE_MUL;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      Result1  <= '0;
      Result2  <= '0;
      DivZero  <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef MCYCLE_SIGNED_EN
      signed_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op_q     <= MCycleOp;
            acc_hi_q <= '0;
            acc_lo_q <= Operand1;
            opb_q    <= Operand2;
            cnt_q    <= '0;
            Busy     <= 1'b1;
            state_q  <= PREP;
`ifdef MCYCLE_SIGNED_EN
            signed_q <= Signed;
`endif
          end
        end
        PREP: begin
          if ((op_q == MCYCLE_DIV) && (opb_q == '0)) begin
            Result1 <= '1;
            Result2 <= acc_lo_q;
            DivZero <= 1'b1;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state_q <= DONE;
          end else begin
            acc_hi_q <= '0;
            acc_lo_q <= (op_q == MCYCLE_MUL) ? mag_b_s : mag_a_s;
            opb_q    <= (op_q == MCYCLE_MUL) ? mag_a_s : mag_b_s;
            state_q  <= ITER;
`ifdef MCYCLE_SIGNED_EN
            // quotient (and product) sign is the XOR; remainder follows the dividend
            neg_lo_q <= sgn_a_s ^ sgn_b_s;
            neg_hi_q <= (op_q == MCYCLE_MUL) ? (sgn_a_s ^ sgn_b_s) : sgn_a_s;
`endif
          end
        end
        ITER: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            if (need_fix_s) begin
              state_q <= FIX;
            end else begin
              Result1 <= acc_lo_d;
              Result2 <= acc_hi_d;
              if (op_q == MCYCLE_DIV) begin
                DivZero <= 1'b0;
              end
              Done    <= 1'b1;
              Busy    <= 1'b0;
              state_q <= DONE;
            end
          end
        end
`ifdef MCYCLE_SIGNED_EN
        FIX: begin
          if (op_q == MCYCLE_MUL) begin
            Result1 <= prod_neg_s[WIDTH-1:0];
            Result2 <= prod_neg_s[2*WIDTH-1:WIDTH];
          end else begin
            Result1 <= quo_neg_s;
            Result2 <= rem_neg_s;
            DivZero <= 1'b0;
          end
          Done    <= 1'b1;
          Busy    <= 1'b0;
          state_q <= DONE;
        end
`endif
        DONE: begin
          Done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_seq.sv
// Self-checking bench for mcycle_seq: vector table plus scoreboard, abort/restart sequence.
module tb_mcycle_seq;

  typedef struct {
    logic        op;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        dz;
    int          lat;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Start = 1'b0;
  logic        MCycleOp = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] Operand1 = 32'd0;
  logic [31:0] Operand2 = 32'd0;
  logic [31:0] Result1, Result2;
  logic        DivZero, Busy, Done;
  logic [31:0] ALU_SrcA, ALU_SrcB, ALU_Result;
  logic [1:0]  ALU_Control;
  logic [3:0]  ALU_Flags;
  logic [32:0] alu_sum;

  int n_checks = 0;
  int n_errors = 0;
  vec_t exp_q[$];
  vec_t tbl[10];

  mcycle_seq #(.WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp), .Signed(Signed),
    .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
    .DivZero(DivZero), .Busy(Busy), .Done(Done), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB),
    .ALU_Control(ALU_Control), .ALU_Result(ALU_Result), .ALU_Flags(ALU_Flags)
  );

  always #5 CLK = ~CLK;

  // Reference ALU: ADD, or SUB as A + ~B + 1 so that C means "no borrow".
  always_comb begin
    if (ALU_Control == 2'b01) alu_sum = {1'b0, ALU_SrcA} + {1'b0, ~ALU_SrcB} + 33'd1;
    else                      alu_sum = {1'b0, ALU_SrcA} + {1'b0, ALU_SrcB};
  end
  assign ALU_Result = alu_sum[31:0];
  assign ALU_Flags  = {alu_sum[31], (alu_sum[31:0] == 32'd0), alu_sum[32], 1'b0};

  function automatic vec_t mk(input logic op, input logic sg, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] r1,
                              input logic [31:0] r2, input logic dz, input int lat);
    vec_t v;
    v.op = op; v.sg = sg; v.a = a; v.b = b; v.r1 = r1; v.r2 = r2; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation, optionally re-pulse Start at cycle 'poke', score the completion.
  task automatic run_vec(input vec_t v, input int poke);
    vec_t e;
    int   lat;
    int   busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = v.op; Signed = v.sg; Operand1 = v.a; Operand2 = v.b;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    Start = 1'b0;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      @(negedge CLK);
      if (cyc == poke) begin
        Start = 1'b1; MCycleOp = ~v.op; Operand1 = 32'd3; Operand2 = 32'd3;
      end else begin
        Start = 1'b0;
      end
      if (cyc == 10 && !v.sg && v.lat > 10) begin
        chk("alu_ctrl_iter", {62'd0, ALU_Control}, v.op ? 64'd1 : 64'd0);
        chk("alu_srcb_iter", {32'd0, ALU_SrcB}, v.op ? {32'd0, v.b} : {32'd0, v.a});
      end
      if (Done) lat = cyc;
      else if (Busy) busy_cnt++;
    end
    Start = 1'b0;
    e = exp_q.pop_front();
    if (lat == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no Done within 40 cycles, expected Done at %0d", e.lat);
    end else begin
      chk("result1", {32'd0, Result1}, {32'd0, e.r1});
      chk("result2", {32'd0, Result2}, {32'd0, e.r2});
      if (e.op) chk("divzero", {63'd0, DivZero}, {63'd0, e.dz});
      chk("done_latency", lat, e.lat);
      chk("busy_cycles", busy_cnt, e.lat - 1);
      chk("busy_at_done", {63'd0, Busy}, 64'd0);
      chk("alu_ctrl_idle", {62'd0, ALU_Control}, 64'd0);
      @(negedge CLK);
      chk("done_pulse_width", {63'd0, Done}, 64'd0);
    end
  endtask

  initial begin
    logic seen;
    tbl[0] = mk(1'b0, 1'b0, 32'd7,          32'd6,          32'd42,         32'd0,          1'b0, 34);
    tbl[1] = mk(1'b0, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE,   1'b0, 34);
    tbl[2] = mk(1'b1, 1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 2);
    tbl[3] = mk(1'b1, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
`ifdef MCYCLE_SIGNED_EN
    tbl[4] = mk(1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 35);
    tbl[5] = mk(1'b0, 1'b1, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   32'hFFFFFFFF,   1'b0, 35);
`else
    tbl[4] = mk(1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 34);
    tbl[5] = mk(1'b0, 1'b1, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   32'd4,          1'b0, 34);
`endif
    tbl[6] = mk(1'b0, 1'b0, 32'h0000FFFF,   32'h00010001,   32'hFFFFFFFF,   32'd0,          1'b0, 34);
    tbl[7] = mk(1'b1, 1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34);
    tbl[8] = mk(1'b1, 1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 34);
    tbl[9] = mk(1'b0, 1'b0, 32'h00010000,   32'h00010000,   32'd0,          32'd1,          1'b0, 34);

    repeat (3) @(negedge CLK);
    chk("rst_busy",    {63'd0, Busy},    64'd0);
    chk("rst_done",    {63'd0, Done},    64'd0);
    chk("rst_divzero", {63'd0, DivZero}, 64'd0);
    chk("rst_result1", {32'd0, Result1}, 64'd0);
    chk("rst_result2", {32'd0, Result2}, 64'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    chk("idle_srca", {32'd0, ALU_SrcA}, 64'd0);
    chk("idle_srcb", {32'd0, ALU_SrcB}, 64'd0);
    chk("idle_busy", {63'd0, Busy},     64'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], (i == 0) ? 5 : 0);
    end

    // Abort a multiply mid-flight with reset, holding Start high while in reset.
    seen = 1'b0;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 1'b0; Signed = 1'b0; Operand1 = 32'd9; Operand2 = 32'd9;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge CLK);
      if (Done) seen = 1'b1;
    end
    chk("abort_busy_before", {63'd0, Busy}, 64'd1);
    RESETn = 1'b0;
    #1;
    chk("abort_busy",    {63'd0, Busy},    64'd0);
    chk("abort_result1", {32'd0, Result1}, 64'd0);
    chk("abort_result2", {32'd0, Result2}, 64'd0);
    chk("abort_srca",    {32'd0, ALU_SrcA}, 64'd0);
    Start = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (Done || Busy) seen = 1'b1;
    end
    Start = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (Done || Busy) seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);

    run_vec(mk(1'b0, 1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 34), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mcycle_seq.md
# mcycle_seq

Multi-cycle multiply/divide sequencer that time-shares the processor's 32-bit 2-bit-control ALU to perform 32x32 multiply and 32/32 divide. It sits beside the execute stage: while a long operation runs, it owns the ALU operand/control inputs and steps them through shift-add or restoring-division iterations. Results come back through a Start/Busy/Done handshake.

## Interface
- WIDTH, 32, operand/ALU width. Only 32 is supported.
- CLK  in  1  rising-edge clock.
- RESETn  in  1  asynchronous, active-low reset.
- Start  in  1  request. Sampled only in IDLE.
- MCycleOp  in  1  0 = multiply, 1 = divide.
- Signed  in  1  1 = two's-complement operands. Honoured only with MCYCLE_SIGNED_EN.
- Operand1, Operand2  in  WIDTH  multiplicand/multiplier, or dividend/divisor. Captured with Start.
- Result1  out  WIDTH  product low word, or quotient.
- Result2  out  WIDTH  product high word, or remainder.
- DivZero  out  1  last divide had divisor 0.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; results valid.
- ALU_SrcA, ALU_SrcB  out  WIDTH  driven to the shared ALU.
- ALU_Control  out  2  00 = ADD, 01 = SUB.
- ALU_Result  in  WIDTH  ALU sum/difference.
- ALU_Flags  in  4  {N,Z,C,V}. Only C (bit 1) is used.

## Operation
- States: IDLE -> PREP -> ITER (x32) -> [FIX] -> DONE -> IDLE.
- IDLE
  - Start=1 captures the operands and op, clears the iteration counter, and moves to PREP.
  - Start while Busy=1 is ignored.
- PREP
  - Signed mode: operands are replaced by their magnitudes; the result signs are recorded.
  - Divide with Operand2=0: Result1=0xFFFFFFFF, Result2=Operand1 (raw), DivZero=1, go to DONE.
- ITER, multiply (shift-add)
  - Accumulator is 64 bits: {hi, lo}, with lo initialised to the multiplier.
  - ALU_SrcA=hi, ALU_SrcB=multiplicand, ALU_Control=ADD.
  - If lo[0]=1: {hi, lo} <= {C, ALU_Result, lo[31:1]}; otherwise {hi, lo} <= {1'b0, hi, lo[31:1]}.
- ITER, divide (restoring)
  - rem' = {rem[30:0], dvd[31]}.
  - ALU_SrcA=rem', ALU_SrcB=divisor, ALU_Control=SUB.
  - C=1 (no borrow): rem <= ALU_Result, quotient bit = 1.
  - C=0: rem <= rem', quotient bit = 0.
  - dvd shifts left one bit, taking in the quotient bit.
- Counter: 5 bits, wraps 31 -> 0 to exit ITER. Exactly 32 iterations.
- FIX (signed only, entered only if a negation is needed)
  - Product negated as a 64-bit value.
  - Quotient sign = XOR of operand signs; remainder takes the dividend's sign.
  - Negation uses internal logic, not the ALU.
- DONE: Done=1, Result1/Result2 updated, then IDLE.
- Results and DivZero hold until the next DONE. DivZero clears on a non-zero-divisor completion.
- Outside ITER: ALU_SrcA=0, ALU_SrcB=0, ALU_Control=00.

## Timing
- Reset values: all outputs 0; state IDLE; accumulators 0.
- Let Start be sampled at edge k.
- Busy is high from k+1 through the cycle before Done.
- Done is high in cycle k+34 with no FIX, or k+35 with FIX. Busy=0 in the Done cycle.
- Divide-by-zero: Done at k+2.
- ALU path is combinational; the result is consumed at the same edge it is produced. The ALU must not be registered.
- A new Start is accepted in the cycle after Done, giving back-to-back issue every 35 or 36 cycles.
- RESETn low mid-operation aborts immediately.
  - Done is not emitted.
  - Results are cleared to 0.
  - Start is ignored while RESETn is low.

## Configuration
- MCYCLE_SIGNED_EN
  - Defined: Signed input honoured; PREP magnitude conversion and the FIX state are present.
  - Undefined: Signed is ignored, all operations are unsigned, the FIX state and negation logic are absent, and latency is always k+34.

## Structure
- Package mcycle_pkg holds:
  - state enum {IDLE, PREP, ITER, FIX, DONE};
  - MCYCLE_MUL = 1'b0 and MCYCLE_DIV = 1'b1;
  - ALU_CTRL_ADD = 2'b00 and ALU_CTRL_SUB = 2'b01;
  - FLAG_C_IDX = 1;
  - ITER_COUNT = 32.
- Sub-module mcycle_negate: parameterised two's-complement negate/abs. Instantiated only under MCYCLE_SIGNED_EN.

## Test plan
- Unsigned multiply, 7 x 6 -> Result1=42, Result2=0, Done at k+34, Busy high for 33 cycles.
- Unsigned multiply, 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE. Checks carry capture.
- Unsigned divide, 100 / 7 -> Result1=14, Result2=2, DivZero=0.
- Divide, 5 / 0 -> Result1=0xFFFFFFFF, Result2=5, DivZero=1, Done at k+2.
- Signed (with MCYCLE_SIGNED_EN), -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF, Done at k+35.
- Same signed case without MCYCLE_SIGNED_EN -> unsigned result (0x7FFFFFFC rem 1).
- Abort and re-start:
  - Start a multiply, pulse Start again at k+5 -> ignored.
  - Pull RESETn low at k+10 -> Busy=0, Results=0, no Done.
  - Start again after reset -> completes normally.
